// File: rtl/single_cycle_mips_core.sv
// single_cycle_mips_core: single-cycle MIPS-subset CPU with internal instruction and data memories
module single_cycle_mips_imem #(
    parameter int WORDS = 256
) (
    input  logic [31:0] addr,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(WORDS);
    logic [31:0] mem_data [WORDS];
    logic        unused_addr;
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
    assign rdata = mem_data[addr[AW+1:2]];
endmodule

module single_cycle_mips_dmem #(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(WORDS);
    logic [31:0] mem_data [WORDS];
    logic        unused_addr;
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
    assign rdata = mem_data[addr[AW+1:2]];
    // word write on the clock edge; out-of-range indices wrap by truncation
    always_ff @(posedge clk)
        if (we) mem_data[addr[AW+1:2]] <= wdata;
endmodule

module single_cycle_mips_core #(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic reset
);
    logic [31:0] PC, instr, next_pc, pc_plus4;
    logic [31:0] rs_val, rt_val, imm_s, imm_z, alu_y, dmem_rdata, wb_data;
    logic [31:0] regs [32];
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wb_addr;
    logic        wb_en, wb_rd, is_lw, is_sw, br_taken, unused_shamt;

    single_cycle_mips_imem #(.WORDS(IMEM_WORDS)) imem (.addr(PC), .rdata(instr));

    single_cycle_mips_dmem #(.WORDS(DMEM_WORDS)) dmem (
        .clk(clk), .we(is_sw & reset), .addr(alu_y), .wdata(rt_val), .rdata(dmem_rdata)
    );

    assign op           = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];
    assign imm_s        = {{16{instr[15]}}, instr[15:0]};
    assign imm_z        = {16'h0, instr[15:0]};
    assign rs_val       = (rs == 5'd0) ? 32'h0 : regs[rs];
    assign rt_val       = (rt == 5'd0) ? 32'h0 : regs[rt];
    assign wb_addr      = wb_rd ? rd : rt;
    assign wb_data      = is_lw ? dmem_rdata : alu_y;
    assign pc_plus4     = PC + 32'd4;
    assign next_pc      = br_taken ? pc_plus4 + {imm_s[29:0], 2'b00} : pc_plus4;

    // decode and execute; unknown opcodes/functs leave every enable low and act as NOPs
    always_comb begin
        alu_y    = '0;
        wb_en    = 1'b0;
        wb_rd    = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        br_taken = 1'b0;
        case (op)
            6'h00: begin
                wb_rd = 1'b1;
                wb_en = 1'b1;
                case (funct)
                    6'h20, 6'h21: alu_y = rs_val + rt_val;
                    6'h22, 6'h23: alu_y = rs_val - rt_val;
                    6'h24:        alu_y = rs_val & rt_val;
                    6'h25:        alu_y = rs_val | rt_val;
                    6'h26:        alu_y = rs_val ^ rt_val;
                    6'h27:        alu_y = ~(rs_val | rt_val);
                    6'h2A:        alu_y = {31'b0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B:        alu_y = {31'b0, rs_val < rt_val};
                    default:      wb_en = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin alu_y = rs_val + imm_s; wb_en = 1'b1; end
            6'h0A:        begin alu_y = {31'b0, $signed(rs_val) < $signed(imm_s)}; wb_en = 1'b1; end
            6'h0B:        begin alu_y = {31'b0, rs_val < imm_s}; wb_en = 1'b1; end
            6'h0C:        begin alu_y = rs_val & imm_z; wb_en = 1'b1; end
            6'h0D:        begin alu_y = rs_val | imm_z; wb_en = 1'b1; end
            6'h0E:        begin alu_y = rs_val ^ imm_z; wb_en = 1'b1; end
            6'h0F:        begin alu_y = {instr[15:0], 16'h0}; wb_en = 1'b1; end
            6'h23:        begin alu_y = rs_val + imm_s; wb_en = 1'b1; is_lw = 1'b1; end
            6'h2B:        begin alu_y = rs_val + imm_s; is_sw = 1'b1; end
            6'h04:        br_taken = (rs_val == rt_val);
            6'h05:        br_taken = (rs_val != rt_val);
            default:      ;
        endcase
    end

    // PC and register file; reset clears both asynchronously and blocks all writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC <= RESET_PC;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            PC <= next_pc;
            if (wb_en && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
        end
    end
endmodule

// File: tb/tb_single_cycle_mips_core.sv
// tb_single_cycle_mips_core: directed program tests for the single-cycle MIPS core
module tb_single_cycle_mips_core;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    single_cycle_mips_core dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    task automatic begin_prog();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) dut.imem.mem_data[i] = 32'h0;
    endtask

    task automatic put(input int a, input logic [31:0] w);
        dut.imem.mem_data[a] = w;
    endtask

    task automatic go();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int nz;
        begin_prog();
        put(0, 32'h34081234);
        put(1, 32'h34090055);
        go();
        step(2);
        vectors++; if (dut.regs[9] !== 32'h55) begin miscompares++; $display("FAIL pre_reset_r9: got %h want %h", dut.regs[9], 32'h55); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (dut.PC !== 32'h0) begin miscompares++; $display("FAIL async_pc: got %h want %h", dut.PC, 32'h0); end
        vectors++; if (dut.regs[8] !== 32'h0) begin miscompares++; $display("FAIL async_r8: got %h want %h", dut.regs[8], 32'h0); end
        repeat (3) @(negedge clk);
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.regs[i] !== 32'h0) nz++;
        vectors++; if (nz != 0) begin miscompares++; $display("FAIL reset_regs: got %0d nonzero want 0", nz); end
        vectors++; if (dut.PC !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", dut.PC, 32'h0); end
        reset = 1'b1;
        step(1);
        vectors++; if (dut.PC !== 32'h4) begin miscompares++; $display("FAIL pc_step1: got %h want %h", dut.PC, 32'h4); end
        step(1);
        vectors++; if (dut.PC !== 32'h8) begin miscompares++; $display("FAIL pc_step2: got %h want %h", dut.PC, 32'h8); end
        step(1);
        vectors++; if (dut.PC !== 32'hC) begin miscompares++; $display("FAIL pc_step3: got %h want %h", dut.PC, 32'hC); end
    endtask

    task automatic test_immediate();
        begin_prog();
        put(0, 32'h34081234);
        put(1, 32'h2129FFFF);
        put(2, 32'h3C03DEAD);
        put(3, 32'h386ABEEF);
        put(4, 32'h312B8001);
        put(5, 32'h292C0000);
        put(6, 32'h2D0DFFFF);
        go();
        step(7);
        vectors++; if (dut.regs[8] !== 32'h00001234) begin miscompares++; $display("FAIL ori: got %h want %h", dut.regs[8], 32'h00001234); end
        vectors++; if (dut.regs[9] !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL addi_neg: got %h want %h", dut.regs[9], 32'hFFFFFFFF); end
        vectors++; if (dut.regs[3] !== 32'hDEAD0000) begin miscompares++; $display("FAIL lui: got %h want %h", dut.regs[3], 32'hDEAD0000); end
        vectors++; if (dut.regs[10] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL xori_zext: got %h want %h", dut.regs[10], 32'hDEADBEEF); end
        vectors++; if (dut.regs[11] !== 32'h00008001) begin miscompares++; $display("FAIL andi_zext: got %h want %h", dut.regs[11], 32'h00008001); end
        vectors++; if (dut.regs[12] !== 32'h1) begin miscompares++; $display("FAIL slti: got %h want %h", dut.regs[12], 32'h1); end
        vectors++; if (dut.regs[13] !== 32'h1) begin miscompares++; $display("FAIL sltiu: got %h want %h", dut.regs[13], 32'h1); end
    endtask

    task automatic test_compare();
        begin_prog();
        put(0, 32'h2001FFFF);
        put(1, 32'h34020001);
        put(2, 32'h0022182A);
        put(3, 32'h0022202B);
        put(4, 32'h34000055);
        put(5, 32'h00412822);
        put(6, 32'h00403027);
        put(7, 32'h00213820);
        put(8, 32'h00224024);
        put(9, 32'h0022483F);
        put(10, 32'hFC09FFFF);
        go();
        step(11);
        vectors++; if (dut.regs[3] !== 32'h1) begin miscompares++; $display("FAIL slt: got %h want %h", dut.regs[3], 32'h1); end
        vectors++; if (dut.regs[4] !== 32'h0) begin miscompares++; $display("FAIL sltu: got %h want %h", dut.regs[4], 32'h0); end
        vectors++; if (dut.regs[0] !== 32'h0) begin miscompares++; $display("FAIL r0_write: got %h want %h", dut.regs[0], 32'h0); end
        vectors++; if (dut.regs[5] !== 32'h2) begin miscompares++; $display("FAIL sub: got %h want %h", dut.regs[5], 32'h2); end
        vectors++; if (dut.regs[6] !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL nor: got %h want %h", dut.regs[6], 32'hFFFFFFFE); end
        vectors++; if (dut.regs[7] !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL add_wrap: got %h want %h", dut.regs[7], 32'hFFFFFFFE); end
        vectors++; if (dut.regs[8] !== 32'h1) begin miscompares++; $display("FAIL and: got %h want %h", dut.regs[8], 32'h1); end
        vectors++; if (dut.regs[9] !== 32'h0) begin miscompares++; $display("FAIL undef_nop: got %h want %h", dut.regs[9], 32'h0); end
        vectors++; if (dut.PC !== 32'h2C) begin miscompares++; $display("FAIL undef_pc: got %h want %h", dut.PC, 32'h2C); end
    endtask

    task automatic test_load_store();
        begin_prog();
        put(0, 32'h3C03CAFE);
        put(1, 32'h3463F00D);
        put(2, 32'hAC030080);
        put(3, 32'h8C040080);
        put(4, 32'h24050100);
        put(5, 32'hACA4FFFC);
        put(6, 32'hACA30400);
        put(7, 32'h8CA70000);
        go();
        step(8);
        vectors++; if (dut.dmem.mem_data[32] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL sw_mem32: got %h want %h", dut.dmem.mem_data[32], 32'hCAFEF00D); end
        vectors++; if (dut.regs[4] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL lw_r4: got %h want %h", dut.regs[4], 32'hCAFEF00D); end
        vectors++; if (dut.dmem.mem_data[63] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL sw_negoff: got %h want %h", dut.dmem.mem_data[63], 32'hCAFEF00D); end
        vectors++; if (dut.dmem.mem_data[64] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL sw_wrap: got %h want %h", dut.dmem.mem_data[64], 32'hCAFEF00D); end
        vectors++; if (dut.regs[7] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL lw_r7: got %h want %h", dut.regs[7], 32'hCAFEF00D); end
    endtask

    task automatic test_branch();
        begin_prog();
        put(0, 32'h34010005);
        put(1, 32'h34020005);
        put(2, 32'h14220004);
        put(3, 32'h10220016);
        put(26, 32'h1000FFF7);
        put(18, 32'h1420000B);
        put(30, 32'h1000FFFF);
        go();
        step(3);
        vectors++; if (dut.PC !== 32'h0C) begin miscompares++; $display("FAIL bne_not_taken: got %h want %h", dut.PC, 32'h0C); end
        step(1);
        vectors++; if (dut.PC !== 32'h68) begin miscompares++; $display("FAIL beq_fwd: got %h want %h", dut.PC, 32'h68); end
        step(1);
        vectors++; if (dut.PC !== 32'h48) begin miscompares++; $display("FAIL beq_back: got %h want %h", dut.PC, 32'h48); end
        step(1);
        vectors++; if (dut.PC !== 32'h78) begin miscompares++; $display("FAIL bne_taken: got %h want %h", dut.PC, 32'h78); end
        step(3);
        vectors++; if (dut.PC !== 32'h78) begin miscompares++; $display("FAIL halt: got %h want %h", dut.PC, 32'h78); end
    endtask

    task automatic test_pc_wrap();
        begin_prog();
        put(0, 32'h1000FFFE);
        put(255, 32'h10000001);
        put(1, 32'h1000FFFF);
        go();
        step(1);
        vectors++; if (dut.PC !== 32'hFFFFFFFC) begin miscompares++; $display("FAIL wrap_down: got %h want %h", dut.PC, 32'hFFFFFFFC); end
        step(1);
        vectors++; if (dut.PC !== 32'h4) begin miscompares++; $display("FAIL wrap_up: got %h want %h", dut.PC, 32'h4); end
    endtask

    task automatic test_sort();
        logic [31:0] model [96];
        logic [31:0] x, t;
        int cycles;
        int j;
        begin_prog();
        put(0, 32'h3C0B9E37);
        put(1, 32'h356B79B9);
        put(2, 32'h34080000);
        put(3, 32'h24090060);
        put(4, 32'h3403DEAD);
        put(5, 32'hAD030080);
        put(6, 32'h00631821);
        put(7, 32'h006B1826);
        put(8, 32'h25080004);
        put(9, 32'h2529FFFF);
        put(10, 32'h1520FFFA);
        put(11, 32'h34020004);
        put(12, 32'h34070180);
        put(13, 32'h8C410080);
        put(14, 32'h00402021);
        put(15, 32'h10800006);
        put(16, 32'h8C85007C);
        put(17, 32'h00A1302B);
        put(18, 32'h10C00003);
        put(19, 32'hAC850080);
        put(20, 32'h2484FFFC);
        put(21, 32'h1000FFF9);
        put(22, 32'hAC810080);
        put(23, 32'h24420004);
        put(24, 32'h1447FFF4);
        put(25, 32'h1000FFFF);
        go();
        cycles = 0;
        while (dut.PC !== 32'h64 && cycles < 40000) begin
            step(1);
            cycles++;
        end
        vectors++; if (dut.PC !== 32'h64) begin miscompares++; $display("FAIL sort_timeout: got pc %h want %h", dut.PC, 32'h64); end
        step(2);
        vectors++; if (dut.PC !== 32'h64) begin miscompares++; $display("FAIL sort_halt: got %h want %h", dut.PC, 32'h64); end
        x = 32'h0000DEAD;
        for (int k = 0; k < 96; k++) begin
            model[k] = x;
            x = (x + x) ^ 32'h9E3779B9;
        end
        for (int k = 1; k < 96; k++) begin
            t = model[k];
            j = k;
            while (j > 0 && model[j-1] < t) begin
                model[j] = model[j-1];
                j--;
            end
            model[j] = t;
        end
        for (int k = 0; k < 96; k++) begin
            vectors++; if (dut.dmem.mem_data[32+k] !== model[k]) begin miscompares++; $display("FAIL sort_word%0d: got %h want %h", k, dut.dmem.mem_data[32+k], model[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_compare();
        test_load_store();
        test_branch();
        test_pc_wrap();
        test_sort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
